mult_operand_sequencer: RTL and testbench
=========================================

Name: mult_operand_sequencer

Overview:
Upstream driver and downstream checker wrapped around a combinational multiplier under test, such as the 8-bit Vedic multiplier. It steps through a deterministic sequence of operand pairs and holds each pair for a fixed settle time. It then samples the multiplier product, compares it against an internal behavioural product, and counts vectors and mismatches. Used on the Nexys 4 DDR for on-board correctness runs of each multiplication algorithm.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH.
SETTLE_CYCLES, 2, cycles each operand pair is held before sampling (minimum 1).
NUM_VECTORS, 256, vectors per run (1 to 65535).
START_IDX, 0, initial 2*WIDTH-bit sequence index.
STRIDE, 1, index increment per vector (modulo 2^(2*WIDTH)).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  begin a run; sampled in IDLE and DONE.
mul_a  out  WIDTH  operand A to multiplier; registered.
mul_b  out  WIDTH  operand B to multiplier; registered.
mul_result  in  2*WIDTH  product from multiplier under test.
busy  out  1  high in DRIVE and CHECK.
done  out  1  high in DONE.
vec_count  out  16  vectors checked in current or last run.
err_count  out  16  mismatches; saturates at 16'hFFFF.
fail_seen  out  1  sticky; at least one mismatch this run.
first_fail_a  out  WIDTH  mul_a of first mismatching vector.
first_fail_b  out  WIDTH  mul_b of first mismatching vector.
first_fail_result  out  2*WIDTH  mul_result of first mismatching vector.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high.
- Reset values: state=IDLE, every output is 0, idx=START_IDX.
- Operand mapping: mul_a = idx[2W-1:W], mul_b = idx[W-1:0], both driven from registers.
- Expected product: unsigned mul_a*mul_b, full 2*WIDTH bits, computed internally and registered while in DRIVE.
- IDLE: start=1 loads idx=START_IDX, clears vec_count, err_count, fail_seen and first_fail_*, and moves to DRIVE. Operands are valid from the next cycle.
- DRIVE: a settle counter runs SETTLE_CYCLES cycles with operands stable, then moves to CHECK. start is ignored.
- CHECK: one cycle.
  - Sample mul_result and increment vec_count.
  - On mismatch: increment err_count (saturating). If fail_seen=0, capture first_fail_* and set fail_seen.
  - If the new vec_count equals NUM_VECTORS, go to DONE. Otherwise idx += STRIDE (wraps) and go to DRIVE.
- Cost: SETTLE_CYCLES+1 cycles per vector. done rises after the (SETTLE_CYCLES+1)*NUM_VECTORS-th edge following the edge that sampled start.
- DONE: all counters and capture registers hold. mul_a and mul_b hold the last vector. start=1 restarts exactly as from IDLE, with counters cleared.
- Status decode: busy = (DRIVE or CHECK); done = DONE.
- Reset mid-run: on the next edge, return to IDLE with all reset values. No partial results are kept.
- start held high continuously: runs back-to-back, restarting from DONE each time.
- err_count saturates and never wraps. vec_count cannot overflow because NUM_VECTORS ≤ 65535.

Test Plan:
1. WIDTH=8, SETTLE=2, N=4, STRIDE=1, START_IDX=0, ideal multiplier, start pulse → operands (0,0),(0,1),(0,2),(0,3). done high 12 edges after the start edge, vec_count=4, err_count=0, fail_seen=0.
2. START_IDX=16'hCD39, N=1, ideal multiplier → mul_a=8'hCD, mul_b=8'h39, expected product 16'h2DA5, err_count=0, done after 3 edges.
3. STRIDE=257, N=4, multiplier model with result bit0 stuck at 0 → vectors (0,0),(1,1),(2,2),(3,3). Mismatches at products 1 and 9: err_count=2, first_fail_a=1, first_fail_b=1, first_fail_result=0.
4. N=4, rst asserted for one cycle while in DRIVE of vector 2 → next cycle state=IDLE, all outputs 0. A new start gives a clean run with vec_count=4.
5. From DONE after scenario 3, start pulse with ideal multiplier → counters and fail_seen cleared at restart, final err_count=0.
6. START_IDX=16'hFFFF, STRIDE=1, N=2 → vectors (FF,FF), then wrap to (00,00). Expected products 16'hFE01 and 0, err_count=0.

Source files
------------

// File: rtl/mult_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mult_operand_sequencer
//
// Drives a deterministic sequence of operand pairs into a combinational
// multiplier under test. It holds each pair for SETTLE_CYCLES cycles and
// then samples the product. The product is compared with an internally
// computed reference, and the block counts vectors and mismatches. It also
// captures the first failing vector.
//
// Ports:
//   clk               in   rising-edge system clock
//   rst               in   synchronous active-high reset
//   start             in   begin a run (honoured in IDLE and DONE)
//   mul_a, mul_b      out  registered operands, idx[2W-1:W] / idx[W-1:0]
//   mul_result        in   product from the multiplier under test
//   busy              out  high while driving / checking vectors
//   done              out  high once the run has completed
//   vec_count         out  vectors checked in the current or last run
//   err_count         out  mismatching vectors, saturating at 16'hFFFF
//   fail_seen         out  sticky flag: at least one mismatch this run
//   first_fail_a/_b   out  operands of the first mismatching vector
//   first_fail_result out  product returned for the first mismatching vector
// ---------------------------------------------------------------------------
module mult_operand_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned START_IDX     = 0,
  parameter int unsigned STRIDE        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count,
  output logic [15:0]          err_count,
  output logic                 fail_seen,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b,
  output logic [2*WIDTH-1:0]   first_fail_result
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0] START_L     = PW'(START_IDX);
  localparam logic [PW-1:0] STRIDE_L    = PW'(STRIDE);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   NV_L        = 16'(NUM_VECTORS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH-1:0]  mul_b_q, mul_b_d;
  logic [PW-1:0]     exp_q, exp_d;
  logic [CW-1:0]     settle_q, settle_d;
  logic [15:0]       vec_q, vec_d;
  logic [15:0]       err_q, err_d;
  logic              fail_q, fail_d;
  logic [WIDTH-1:0]  ff_a_q, ff_a_d;
  logic [WIDTH-1:0]  ff_b_q, ff_b_d;
  logic [PW-1:0]     ff_res_q, ff_res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PW-1:0]     next_idx_s;
  logic [15:0]       vec_inc_s;

  assign next_idx_s = idx_q + STRIDE_L;   // wraps modulo 2^PW
  assign vec_inc_s  = vec_q + 16'd1;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= START_L;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      exp_q    <= '0;
      settle_q <= '0;
      vec_q    <= 16'd0;
      err_q    <= 16'd0;
      fail_q   <= 1'b0;
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_res_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      exp_q    <= exp_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      ff_a_q   <= ff_a_d;
      ff_b_q   <= ff_b_d;
      ff_res_q <= ff_res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, counter and capture logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    exp_d    = exp_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fail_d   = fail_q;
    ff_a_d   = ff_a_q;
    ff_b_d   = ff_b_q;
    ff_res_d = ff_res_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Restart from DONE behaves exactly like a start from IDLE.
          state_d  = S_DRIVE;
          idx_d    = START_L;
          mul_a_d  = START_L[PW-1:WIDTH];
          mul_b_d  = START_L[WIDTH-1:0];
          settle_d = '0;
          vec_d    = 16'd0;
          err_d    = 16'd0;
          fail_d   = 1'b0;
          ff_a_d   = '0;
          ff_b_d   = '0;
          ff_res_d = '0;
        end else begin
          state_d = state_q;
        end
      end

      S_DRIVE: begin
        // Operands are stable throughout DRIVE, so the reference product
        // is valid by the time CHECK samples it.
        exp_d = PW'(mul_a_q) * PW'(mul_b_q);
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + CW'(1);
        end
      end

      S_CHECK: begin
        vec_d = vec_inc_s;
        if (mul_result != exp_q) begin
          err_d = (err_q == 16'hFFFF) ? err_q : (err_q + 16'd1);
          if (!fail_q) begin
            fail_d   = 1'b1;
            ff_a_d   = mul_a_q;
            ff_b_d   = mul_b_q;
            ff_res_d = mul_result;
          end else begin
            fail_d = fail_q;
          end
        end else begin
          err_d = err_q;
        end
        if (vec_inc_s == NV_L) begin
          // Operands keep showing the last vector while in DONE.
          state_d = S_DONE;
        end else begin
          idx_d   = next_idx_s;
          mul_a_d = next_idx_s[PW-1:WIDTH];
          mul_b_d = next_idx_s[WIDTH-1:0];
          state_d = S_DRIVE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so that they are registered
  // and line up with the state register.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_DRIVE, S_CHECK: busy_d = 1'b1;
      S_DONE:           done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign mul_a             = mul_a_q;
  assign mul_b             = mul_b_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign vec_count         = vec_q;
  assign err_count         = err_q;
  assign fail_seen         = fail_q;
  assign first_fail_a      = ff_a_q;
  assign first_fail_b      = ff_b_q;
  assign first_fail_result = ff_res_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
module tb_mult_operand_sequencer;

  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic        start_s   [4];
  logic [7:0]  mul_a     [4];
  logic [7:0]  mul_b     [4];
  logic [15:0] mul_result[4];
  logic        busy      [4];
  logic        done      [4];
  logic [15:0] vec_count [4];
  logic [15:0] err_count [4];
  logic        fail_seen [4];
  logic [7:0]  ff_a      [4];
  logic [7:0]  ff_b      [4];
  logic [15:0] ff_res    [4];
  logic        stuck0;

  int checks;
  int failures;
  logic [15:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multipliers under test: ideal for instances 0, 1 and 3, and optionally
  // bit0-stuck-at-0 for instance 2.
  assign mul_result[0] = 16'(mul_a[0]) * 16'(mul_b[0]);
  assign mul_result[1] = 16'(mul_a[1]) * 16'(mul_b[1]);
  assign mul_result[2] = (16'(mul_a[2]) * 16'(mul_b[2])) & ~{15'd0, stuck0};
  assign mul_result[3] = 16'(mul_a[3]) * 16'(mul_b[3]);

  mult_operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S), .NUM_VECTORS(4),
                           .START_IDX(0), .STRIDE(1)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_result(mul_result[0]), .busy(busy[0]), .done(done[0]),
    .vec_count(vec_count[0]), .err_count(err_count[0]), .fail_seen(fail_seen[0]),
    .first_fail_a(ff_a[0]), .first_fail_b(ff_b[0]), .first_fail_result(ff_res[0]));

  mult_operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S), .NUM_VECTORS(1),
                           .START_IDX(32'hCD39), .STRIDE(1)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_result(mul_result[1]), .busy(busy[1]), .done(done[1]),
    .vec_count(vec_count[1]), .err_count(err_count[1]), .fail_seen(fail_seen[1]),
    .first_fail_a(ff_a[1]), .first_fail_b(ff_b[1]), .first_fail_result(ff_res[1]));

  mult_operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S), .NUM_VECTORS(4),
                           .START_IDX(0), .STRIDE(257)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .mul_a(mul_a[2]), .mul_b(mul_b[2]),
    .mul_result(mul_result[2]), .busy(busy[2]), .done(done[2]),
    .vec_count(vec_count[2]), .err_count(err_count[2]), .fail_seen(fail_seen[2]),
    .first_fail_a(ff_a[2]), .first_fail_b(ff_b[2]), .first_fail_result(ff_res[2]));

  mult_operand_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S), .NUM_VECTORS(2),
                           .START_IDX(32'hFFFF), .STRIDE(1)) u3 (
    .clk(clk), .rst(rst), .start(start_s[3]), .mul_a(mul_a[3]), .mul_b(mul_b[3]),
    .mul_result(mul_result[3]), .busy(busy[3]), .done(done[3]),
    .vec_count(vec_count[3]), .err_count(err_count[3]), .fail_seen(fail_seen[3]),
    .first_fail_a(ff_a[3]), .first_fail_b(ff_b[3]), .first_fail_result(ff_res[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input int u, input string tag);
    chk({tag, " mul_a"},     32'(mul_a[u]), 32'd0);
    chk({tag, " mul_b"},     32'(mul_b[u]), 32'd0);
    chk({tag, " busy"},      32'(busy[u]), 32'd0);
    chk({tag, " done"},      32'(done[u]), 32'd0);
    chk({tag, " vec_count"}, 32'(vec_count[u]), 32'd0);
    chk({tag, " err_count"}, 32'(err_count[u]), 32'd0);
    chk({tag, " fail_seen"}, 32'(fail_seen[u]), 32'd0);
    chk({tag, " ff_a"},      32'(ff_a[u]), 32'd0);
    chk({tag, " ff_b"},      32'(ff_b[u]), 32'd0);
    chk({tag, " ff_res"},    32'(ff_res[u]), 32'd0);
  endtask

  // Pulse start on instance u, then follow every vector with cycle-exact
  // expectations drawn from the scoreboard queue, and finally check totals.
  task automatic run(input int u, input int n, input logic [15:0] sidx,
                     input logic [15:0] stride, input logic faulty, input string tag);
    logic [15:0] v;
    logic [15:0] prod;
    logic [15:0] got;
    int          exp_err;
    logic        exp_fail;
    logic [7:0]  exp_fa;
    logic [7:0]  exp_fb;
    logic [15:0] exp_fr;
    exp_err = 0; exp_fail = 1'b0; exp_fa = 8'd0; exp_fb = 8'd0; exp_fr = 16'd0;
    @(negedge clk); start_s[u] = 1'b1;
    @(negedge clk); start_s[u] = 1'b0;
    chk({tag, " busy@start"}, 32'(busy[u]), 32'd1);
    chk({tag, " vec@start"},  32'(vec_count[u]), 32'd0);
    chk({tag, " err@start"},  32'(err_count[u]), 32'd0);
    chk({tag, " fail@start"}, 32'(fail_seen[u]), 32'd0);
    for (int k = 0; k < n; k++) sb_q.push_back(sidx + 16'(k) * stride);
    for (int k = 0; k < n; k++) begin
      v = sb_q.pop_front();
      chk({tag, " mul_a"}, 32'(mul_a[u]), 32'(v[15:8]));
      chk({tag, " mul_b"}, 32'(mul_b[u]), 32'(v[7:0]));
      prod = 16'(v[15:8]) * 16'(v[7:0]);
      got  = faulty ? (prod & 16'hFFFE) : prod;
      if (got != prod) begin
        exp_err++;
        if (!exp_fail) begin
          exp_fail = 1'b1; exp_fa = v[15:8]; exp_fb = v[7:0]; exp_fr = got;
        end
      end
      repeat (S) @(negedge clk);
      if (k == n - 1) chk({tag, " done_early"}, 32'(done[u]), 32'd0);
      @(negedge clk);
      chk({tag, " vec_count"}, 32'(vec_count[u]), 32'(k + 1));
    end
    chk({tag, " done"},      32'(done[u]), 32'd1);
    chk({tag, " busy_end"},  32'(busy[u]), 32'd0);
    chk({tag, " err_count"}, 32'(err_count[u]), 32'(exp_err));
    chk({tag, " fail_seen"}, 32'(fail_seen[u]), 32'(exp_fail));
    chk({tag, " ff_a"},      32'(ff_a[u]), 32'(exp_fa));
    chk({tag, " ff_b"},      32'(ff_b[u]), 32'(exp_fb));
    chk({tag, " ff_res"},    32'(ff_res[u]), 32'(exp_fr));
  endtask

  initial begin
    checks = 0; failures = 0;
    stuck0 = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) start_s[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_cleared(i, "reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic run: (0,0),(0,1),(0,2),(0,3), done 12 edges after start.
    run(0, 4, 16'h0000, 16'd1, 1'b0, "s1");

    // Reset during DRIVE of vector 2, then a clean rerun.
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (2 * (S + 1)) @(negedge clk);
    chk("s4 mul_b_v2", 32'(mul_b[0]), 32'd2);
    chk("s4 busy_v2",  32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_cleared(0, "s4 after_rst");
    run(0, 4, 16'h0000, 16'd1, 1'b0, "s4");

    // Single vector CD x 39.
    run(1, 1, 16'hCD39, 16'd1, 1'b0, "s2");
    chk("s2 product", 32'(mul_result[1]), 32'h2DA5);

    // Faulty multiplier with diagonal stride.
    stuck0 = 1'b1;
    run(2, 4, 16'h0000, 16'd257, 1'b1, "s3");
    chk("s3 err_spec",  32'(err_count[2]), 32'd2);
    chk("s3 ffres_spec", 32'(ff_res[2]), 32'd0);

    // Restart from DONE with an ideal multiplier clears the error state.
    stuck0 = 1'b0;
    run(2, 4, 16'h0000, 16'd257, 1'b0, "s5");

    // Index wrap: (FF,FF) then (00,00).
    run(3, 2, 16'hFFFF, 16'd1, 1'b0, "s6");
    chk("s6 last_a", 32'(mul_a[3]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
